// File: rtl/cart_pkg.sv
// Shared types and constants for the cartridge bank-switch controller.
// Optional macro CART_MAPPER_F4_EN enables the 32K F4 size and its eight-bank decode.
package cart_pkg;

  typedef enum logic [1:0] {
    SIZE_4K = 2'b00,
    SIZE_F8 = 2'b01,
    SIZE_F4 = 2'b10,
    SIZE_F6 = 2'b11
  } size_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

  localparam logic [12:0] HS_F8 = 13'h1FF8;
  localparam logic [12:0] HS_F6 = 13'h1FF6;
  localparam logic [12:0] HS_F4 = 13'h1FF4;

  // SuperChip windows are 128 bytes, so only address bits [12:7] select them
  localparam logic [12:0] SC_WR_BASE = 13'h1000;
  localparam logic [12:0] SC_RD_BASE = 13'h1080;

  function automatic size_e size_of(input logic [2:0] page);
    size_e s;
    case (page)
      3'd0:       s = SIZE_4K;
      3'd1:       s = SIZE_F8;
      3'd2, 3'd3: s = SIZE_F6;
`ifdef CART_MAPPER_F4_EN
      default:    s = SIZE_F4;
`else
      default:    s = SIZE_F6;
`endif
    endcase
    return s;
  endfunction

  function automatic logic [2:0] bank_mask(input size_e s, input logic [2:0] b);
    logic [2:0] m;
    case (s)
      SIZE_4K: m = 3'b000;
      SIZE_F8: m = {2'b00, b[0]};
      SIZE_F6: m = {1'b0, b[1:0]};
`ifdef CART_MAPPER_F4_EN
      SIZE_F4: m = b;
`endif
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cart_hotspot_dec.sv
// Combinational hotspot decoder: maps a CPU address to a bank for the current ROM size.
// F4 decode exists only when CART_MAPPER_F4_EN is defined.
module cart_hotspot_dec
  import cart_pkg::*;
(
  input  logic [1:0]  rom_size_i,
  input  logic [12:0] cpu_addr_i,
  output logic        hit_o,
  output logic [2:0]  new_bank_o
);

  logic [12:0] off_s;

  // Offset from the size's hotspot base; addresses below the base wrap high and miss
  always_comb begin
    hit_o      = 1'b0;
    new_bank_o = 3'b000;
    off_s      = 13'd0;
    case (rom_size_i)
      SIZE_F8: begin
        off_s = cpu_addr_i - HS_F8;
        if (off_s < 13'd2) begin
          hit_o      = 1'b1;
          new_bank_o = off_s[2:0];
        end else begin
          hit_o      = 1'b0;
          new_bank_o = 3'b000;
        end
      end
      SIZE_F6: begin
        off_s = cpu_addr_i - HS_F6;
        if (off_s < 13'd4) begin
          hit_o      = 1'b1;
          new_bank_o = off_s[2:0];
        end else begin
          hit_o      = 1'b0;
          new_bank_o = 3'b000;
        end
      end
`ifdef CART_MAPPER_F4_EN
      SIZE_F4: begin
        off_s = cpu_addr_i - HS_F4;
        if (off_s < 13'd8) begin
          hit_o      = 1'b1;
          new_bank_o = off_s[2:0];
        end else begin
          hit_o      = 1'b0;
          new_bank_o = 3'b000;
        end
      end
`endif
      default: begin
        hit_o      = 1'b0;
        new_bank_o = 3'b000;
      end
    endcase
  end

endmodule

// File: rtl/cart_mapper.sv
// Cartridge bank-switch controller: load-time size tracking, hotspot banking, SuperChip selects.
// Optional macro CART_MAPPER_F4_EN adds the 32K F4 size with live bank_o[2].
module cart_mapper
  import cart_pkg::*;
#(
  parameter bit         SC_EN      = 1'b1,
  parameter logic [2:0] START_BANK = 3'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_rst_i,
  input  logic        cpu_en_i,
  input  logic [12:0] cpu_addr_i,
  input  logic        cpu_we_i,
  input  logic        load_active_i,
  input  logic        load_we_i,
  input  logic [14:0] load_addr_i,
  input  logic        sc_disable_i,
  output logic [14:0] rom_addr_o,
  output logic [2:0]  bank_o,
  output logic [1:0]  rom_size_o,
  output logic        cart_ram_rd_cs_o,
  output logic        cart_ram_we_o,
  output logic [6:0]  cart_ram_addr_o,
  output logic        loading_o
);

  state_e     state_q, state_d;
  size_e      size_q, size_d, size_new_s;
  logic [2:0] bank_q, bank_d;
  logic [2:0] max_page_q, max_page_d, page_eff_s;
  logic       hs_hit_s;
  logic [2:0] hs_bank_s;
  logic       sc_active_s;
  logic       load_addr_unused;

  assign load_addr_unused = ^load_addr_i[11:0];

  cart_hotspot_dec u_dec (
    .rom_size_i (size_q),
    .cpu_addr_i (cpu_addr_i),
    .hit_o      (hs_hit_s),
    .new_bank_o (hs_bank_s)
  );

  // Next state: FSM, load-size tracking and bank register
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    bank_d     = bank_q;
    max_page_d = max_page_q;
    // A write on the final LOAD cycle still counts toward the size
    if (load_we_i && (load_addr_i[14:12] > max_page_q)) begin
      page_eff_s = load_addr_i[14:12];
    end else begin
      page_eff_s = max_page_q;
    end
    size_new_s = size_of(page_eff_s);
    case (state_q)
      ST_RUN: begin
        if (cpu_en_i && hs_hit_s) begin
          bank_d = hs_bank_s;
        end else begin
          bank_d = bank_q;
        end
        if (cpu_rst_i) begin
          bank_d = bank_mask(size_q, START_BANK);
        end else begin
          bank_d = bank_d;
        end
        if (load_active_i) begin
          state_d    = ST_LOAD;
          max_page_d = 3'd0;
        end else begin
          state_d    = ST_RUN;
          max_page_d = max_page_q;
        end
      end
      ST_LOAD: begin
        max_page_d = page_eff_s;
        if (cpu_rst_i) begin
          bank_d = bank_mask(size_q, START_BANK);
        end else begin
          bank_d = bank_q;
        end
        if (!load_active_i) begin
          state_d = ST_RUN;
          size_d  = size_new_s;
          bank_d  = bank_mask(size_new_s, START_BANK);
        end else begin
          state_d = ST_LOAD;
          size_d  = size_q;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
`ifndef CART_MAPPER_F4_EN
    bank_d[2] = 1'b0;
`endif
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_RUN;
      size_q     <= SIZE_4K;
      bank_q     <= bank_mask(SIZE_4K, START_BANK);
      max_page_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      bank_q     <= bank_d;
      max_page_q <= max_page_d;
    end
  end

  // SuperChip decode is live only for F6 images while running
  always_comb begin
    sc_active_s      = SC_EN && (size_q == SIZE_F6) && !sc_disable_i && (state_q == ST_RUN);
    cart_ram_we_o    = sc_active_s && (cpu_addr_i[12:7] == SC_WR_BASE[12:7]) && cpu_we_i && cpu_en_i;
    cart_ram_rd_cs_o = sc_active_s && (cpu_addr_i[12:7] == SC_RD_BASE[12:7]) && !cpu_we_i;
  end

  assign bank_o          = bank_q;
  assign rom_addr_o      = {bank_q, cpu_addr_i[11:0]};
  assign rom_size_o      = size_q;
  assign cart_ram_addr_o = cpu_addr_i[6:0];
  assign loading_o       = (state_q == ST_LOAD);

endmodule

// File: tb/tb_cart_mapper.sv
// Table-driven bench for cart_mapper: one row per clock, expectations queued at drive time.
// Expected values for the 32K image depend on CART_MAPPER_F4_EN.
module tb_cart_mapper;

  logic        clk = 1'b0;
  logic        rst_i, cpu_rst_i, cpu_en_i, cpu_we_i;
  logic [12:0] cpu_addr_i;
  logic        load_active_i, load_we_i, sc_disable_i;
  logic [14:0] load_addr_i;
  logic [14:0] rom_addr_o;
  logic [2:0]  bank_o;
  logic [1:0]  rom_size_o;
  logic        cart_ram_rd_cs_o, cart_ram_we_o, loading_o;
  logic [6:0]  cart_ram_addr_o;

  always #5 clk = ~clk;

  cart_mapper dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .cpu_rst_i        (cpu_rst_i),
    .cpu_en_i         (cpu_en_i),
    .cpu_addr_i       (cpu_addr_i),
    .cpu_we_i         (cpu_we_i),
    .load_active_i    (load_active_i),
    .load_we_i        (load_we_i),
    .load_addr_i      (load_addr_i),
    .sc_disable_i     (sc_disable_i),
    .rom_addr_o       (rom_addr_o),
    .bank_o           (bank_o),
    .rom_size_o       (rom_size_o),
    .cart_ram_rd_cs_o (cart_ram_rd_cs_o),
    .cart_ram_we_o    (cart_ram_we_o),
    .cart_ram_addr_o  (cart_ram_addr_o),
    .loading_o        (loading_o)
  );

`ifdef CART_MAPPER_F4_EN
  localparam logic [1:0] BIG_SZ = 2'b10;
  localparam logic [2:0] B_FFB  = 3'd7;
  localparam logic [2:0] B_FF9  = 3'd5;
`else
  localparam logic [1:0] BIG_SZ = 2'b11;
  localparam logic [2:0] B_FFB  = 3'd0;
  localparam logic [2:0] B_FF9  = 3'd3;
`endif

  typedef struct {
    logic        rst, crst, en, we;
    logic [12:0] addr;
    logic        la, lwe;
    logic [14:0] laddr;
    logic        sd;
    logic [2:0]  eb;
    logic [1:0]  es;
    logic        eld, ewe, erd;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void add(input logic rst, crst, en, we, input logic [12:0] addr,
                              input logic la, lwe, input logic [14:0] laddr, input logic sd,
                              input logic [2:0] eb, input logic [1:0] es,
                              input logic eld, ewe, erd);
    vec_t v;
    v.rst = rst; v.crst = crst; v.en = en; v.we = we; v.addr = addr;
    v.la = la; v.lwe = lwe; v.laddr = laddr; v.sd = sd;
    v.eb = eb; v.es = es; v.eld = eld; v.ewe = ewe; v.erd = erd;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input int idx, input logic [14:0] act, input logic [14:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_i = v.rst; cpu_rst_i = v.crst; cpu_en_i = v.en; cpu_we_i = v.we;
    cpu_addr_i = v.addr; load_active_i = v.la; load_we_i = v.lwe;
    load_addr_i = v.laddr; sc_disable_i = v.sd;
  endtask

  initial begin
    vec_t e;
    // reset state
    add(0,0,0,0,13'h0000, 0,0,15'h0000, 0,  3'd0,2'b00, 0,0,0);
    // 8K load then F8 hotspots
    add(0,0,0,0,13'h0000, 1,0,15'h0000, 0,  3'd0,2'b00, 0,0,0);
    add(0,0,0,0,13'h0000, 1,1,15'h0000, 0,  3'd0,2'b00, 1,0,0);
    add(0,0,0,0,13'h0000, 1,1,15'h1FFF, 0,  3'd0,2'b00, 1,0,0);
    add(0,0,0,0,13'h0000, 0,0,15'h0000, 0,  3'd0,2'b00, 1,0,0);
    add(0,0,1,0,13'h1FF9, 0,0,15'h0000, 0,  3'd0,2'b01, 0,0,0);
    add(0,0,0,0,13'h1123, 0,0,15'h0000, 0,  3'd1,2'b01, 0,0,0);
    add(0,0,1,0,13'h1FF8, 0,0,15'h0000, 0,  3'd1,2'b01, 0,0,0);
    add(0,0,1,1,13'h1000, 0,0,15'h0000, 0,  3'd0,2'b01, 0,0,0);
    // 16K load then F6 hotspots
    add(0,0,0,0,13'h0000, 1,0,15'h0000, 0,  3'd0,2'b01, 0,0,0);
    add(0,0,0,0,13'h0000, 1,1,15'h3FFF, 0,  3'd0,2'b01, 1,0,0);
    add(0,0,0,0,13'h0000, 0,0,15'h0000, 0,  3'd0,2'b01, 1,0,0);
    add(0,0,1,0,13'h1FF8, 0,0,15'h0000, 0,  3'd0,2'b11, 0,0,0);
    add(0,0,1,0,13'h1FF6, 0,0,15'h0000, 0,  3'd2,2'b11, 0,0,0);
    add(0,0,0,0,13'h1FF9, 0,0,15'h0000, 0,  3'd0,2'b11, 0,0,0);
    add(0,0,0,0,13'h0000, 0,0,15'h0000, 0,  3'd0,2'b11, 0,0,0);
    // SuperChip windows
    add(0,0,1,1,13'h1005, 0,0,15'h0000, 0,  3'd0,2'b11, 0,1,0);
    add(0,0,1,0,13'h1085, 0,0,15'h0000, 0,  3'd0,2'b11, 0,0,1);
    add(0,0,1,1,13'h1085, 0,0,15'h0000, 0,  3'd0,2'b11, 0,0,0);
    add(0,0,1,0,13'h1005, 0,0,15'h0000, 0,  3'd0,2'b11, 0,0,0);
    add(0,0,0,1,13'h1005, 0,0,15'h0000, 0,  3'd0,2'b11, 0,0,0);
    add(0,0,1,1,13'h1005, 0,0,15'h0000, 1,  3'd0,2'b11, 0,0,0);
    add(0,0,1,0,13'h1085, 0,0,15'h0000, 1,  3'd0,2'b11, 0,0,0);
    add(0,0,1,1,13'h107F, 0,0,15'h0000, 0,  3'd0,2'b11, 0,1,0);
    add(0,0,1,0,13'h10FF, 0,0,15'h0000, 0,  3'd0,2'b11, 0,0,1);
    add(0,0,1,1,13'h1100, 0,0,15'h0000, 0,  3'd0,2'b11, 0,0,0);
    add(0,0,0,0,13'h10FF, 0,0,15'h0000, 0,  3'd0,2'b11, 0,0,1);
    // CPU soft reset returns to START_BANK, keeps size
    add(0,0,1,0,13'h1FF9, 0,0,15'h0000, 0,  3'd0,2'b11, 0,0,0);
    add(0,0,0,0,13'h0000, 0,0,15'h0000, 0,  3'd3,2'b11, 0,0,0);
    add(0,1,0,0,13'h0000, 0,0,15'h0000, 0,  3'd3,2'b11, 0,0,0);
    add(0,0,0,0,13'h0000, 0,0,15'h0000, 0,  3'd0,2'b11, 0,0,0);
    // hotspot coincident with load start; empty load gives 4K
    add(0,0,1,0,13'h1FF7, 1,0,15'h0000, 0,  3'd0,2'b11, 0,0,0);
    add(0,0,0,0,13'h0000, 1,0,15'h0000, 0,  3'd1,2'b11, 1,0,0);
    add(0,0,1,0,13'h1FF9, 1,0,15'h0000, 0,  3'd1,2'b11, 1,0,0);
    add(0,0,1,1,13'h1005, 1,0,15'h0000, 0,  3'd1,2'b11, 1,0,0);
    add(0,0,0,0,13'h0000, 0,0,15'h0000, 0,  3'd1,2'b11, 1,0,0);
    add(0,0,0,0,13'h0000, 0,0,15'h0000, 0,  3'd0,2'b00, 0,0,0);
    // rst_i aborts a load
    add(0,0,0,0,13'h0000, 1,0,15'h0000, 0,  3'd0,2'b00, 0,0,0);
    add(0,0,0,0,13'h0000, 1,1,15'h3FFF, 0,  3'd0,2'b00, 1,0,0);
    add(1,0,0,0,13'h0000, 1,0,15'h0000, 0,  3'd0,2'b00, 1,0,0);
    add(0,0,0,0,13'h0000, 0,0,15'h0000, 0,  3'd0,2'b00, 0,0,0);
    // 4K load: no hotspots
    add(0,0,0,0,13'h0000, 1,0,15'h0000, 0,  3'd0,2'b00, 0,0,0);
    add(0,0,0,0,13'h0000, 1,1,15'h0FFF, 0,  3'd0,2'b00, 1,0,0);
    add(0,0,0,0,13'h0000, 0,0,15'h0000, 0,  3'd0,2'b00, 1,0,0);
    add(0,0,1,0,13'h1FF8, 0,0,15'h0000, 0,  3'd0,2'b00, 0,0,0);
    add(0,0,0,0,13'h0123, 0,0,15'h0000, 0,  3'd0,2'b00, 0,0,0);
    // 32K load
    add(0,0,0,0,13'h0000, 1,0,15'h0000, 0,  3'd0,2'b00, 0,0,0);
    add(0,0,0,0,13'h0000, 1,1,15'h7FFF, 0,  3'd0,2'b00, 1,0,0);
    add(0,0,0,0,13'h0000, 0,0,15'h0000, 0,  3'd0,2'b00, 1,0,0);
    add(0,0,1,0,13'h1FFB, 0,0,15'h0000, 0,  3'd0,BIG_SZ, 0,0,0);
    add(0,0,1,0,13'h1FF9, 0,0,15'h0000, 0,  B_FFB,BIG_SZ, 0,0,0);
    add(0,0,0,0,13'h0123, 0,0,15'h0000, 0,  B_FF9,BIG_SZ, 0,0,0);

    drive(vecs[0]);
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      exp_q.push_back(vecs[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      check("bank",     i, {12'd0, bank_o},           {12'd0, e.eb});
      check("size",     i, {13'd0, rom_size_o},       {13'd0, e.es});
      check("loading",  i, {14'd0, loading_o},        {14'd0, e.eld});
      check("ram_we",   i, {14'd0, cart_ram_we_o},    {14'd0, e.ewe});
      check("ram_rd",   i, {14'd0, cart_ram_rd_cs_o}, {14'd0, e.erd});
      check("rom_addr", i, rom_addr_o,                {e.eb, e.addr[11:0]});
      check("ram_addr", i, {8'd0, cart_ram_addr_o},   {8'd0, e.addr[6:0]});
      @(posedge clk);
      #1;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
